// File: rtl/apb_controller.sv
// APB-side sequencer of the AHB-to-APB bridge: turns each qualified AHB transfer into one
// APB SETUP/ACCESS sequence and stalls the AHB master via Hreadyout while it is in flight.
module apb_controller (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        valid,
    input  logic [2:0]  tempselx,
    input  logic        Hwrite,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    output logic [2:0]  Pselx,
    output logic        Penable,
    output logic        Pwrite,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    output logic        Hreadyout
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StRenable,
        StWwait,
        StWrite,
        StWenable
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  pselx_q, pselx_d;
    logic [2:0]  sel_lat_q, sel_lat_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        hreadyout_q, hreadyout_d;

    // Accept a new transfer only where Hreadyout is high: IDLE and the two ACCESS states.
    logic accept_point;
    assign accept_point = (state_q == StIdle) || (state_q == StRenable) ||
                          (state_q == StWenable);

    always_comb begin
        state_d     = state_q;
        pselx_d     = pselx_q;
        sel_lat_d   = sel_lat_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        hreadyout_d = hreadyout_q;

        if (accept_point) begin
            if (valid && !Hwrite) begin
                state_d     = StRead;
                paddr_d     = Haddr;
                pselx_d     = tempselx;
                pwrite_d    = 1'b0;
                penable_d   = 1'b0;
                hreadyout_d = 1'b0;
            end else if (valid && Hwrite) begin
                // Write data arrives one cycle later, so park the select until then.
                state_d     = StWwait;
                paddr_d     = Haddr;
                sel_lat_d   = tempselx;
                pselx_d     = 3'b000;
                penable_d   = 1'b0;
                hreadyout_d = 1'b0;
            end else begin
                state_d     = StIdle;
                pselx_d     = 3'b000;
                penable_d   = 1'b0;
                hreadyout_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                StRead: begin
                    state_d     = StRenable;
                    penable_d   = 1'b1;
                    hreadyout_d = 1'b1;
                end
                StWwait: begin
                    state_d     = StWrite;
                    pwdata_d    = Hwdata;
                    pselx_d     = sel_lat_q;
                    pwrite_d    = 1'b1;
                    penable_d   = 1'b0;
                    hreadyout_d = 1'b0;
                end
                StWrite: begin
                    state_d     = StWenable;
                    penable_d   = 1'b1;
                    hreadyout_d = 1'b1;
                end
                default: begin
                    state_d     = StIdle;
                    pselx_d     = 3'b000;
                    penable_d   = 1'b0;
                    hreadyout_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q     <= StIdle;
            pselx_q     <= 3'b000;
            sel_lat_q   <= 3'b000;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 32'h0;
            pwdata_q    <= 32'h0;
            hreadyout_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pselx_q     <= pselx_d;
            sel_lat_q   <= sel_lat_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            hreadyout_q <= hreadyout_d;
        end
    end

    assign Pselx     = pselx_q;
    assign Penable   = penable_q;
    assign Pwrite    = pwrite_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign Hreadyout = hreadyout_q;

endmodule

// File: tb/tb_apb_controller.sv
// Directed bench for apb_controller: reset, single read/write, back-to-back, idle hold and a
// randomised APB legality sweep.
`timescale 1ns/1ps
module tb_apb_controller;

    logic        Hclk;
    logic        Hresetn;
    logic        valid;
    logic [2:0]  tempselx;
    logic        Hwrite;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Hreadyout;

    int checks   = 0;
    int failures = 0;

    apb_controller dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .valid     (valid),
        .tempselx  (tempselx),
        .Hwrite    (Hwrite),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Hreadyout (Hreadyout)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_pselx"}, {29'h0, Pselx}, 32'h0);
        chk({tag, "_penable"}, {31'h0, Penable}, 32'h0);
        chk({tag, "_hready"}, {31'h0, Hreadyout}, 32'h1);
    endtask

    logic        pen_prev;
    logic [2:0]  sel_prev;
    logic [31:0] addr_prev;
    logic [31:0] wdata_prev;
    logic        wr_prev;
    logic [1:0]  region;

    initial begin
        Hresetn  = 1'b1;
        valid    = 1'b0;
        tempselx = 3'b000;
        Hwrite   = 1'b0;
        Haddr    = 32'h0;
        Hwdata   = 32'h0;
        #1 Hresetn = 1'b0;
        #1;
        chk("rst_pselx",   {29'h0, Pselx},     32'h0);
        chk("rst_penable", {31'h0, Penable},   32'h0);
        chk("rst_pwrite",  {31'h0, Pwrite},    32'h0);
        chk("rst_paddr",   Paddr,              32'h0);
        chk("rst_pwdata",  Pwdata,             32'h0);
        chk("rst_hready",  {31'h0, Hreadyout}, 32'h1);
        tick();
        tick();
        Hresetn = 1'b1;
        tick();
        chk_idle("post_rst");

        // Single read
        valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8000_0010; tempselx = 3'b001;
        tick();
        valid = 1'b0;
        chk("rd_setup_pselx",   {29'h0, Pselx},     32'h1);
        chk("rd_setup_paddr",   Paddr,              32'h8000_0010);
        chk("rd_setup_penable", {31'h0, Penable},   32'h0);
        chk("rd_setup_hready",  {31'h0, Hreadyout}, 32'h0);
        chk("rd_setup_pwrite",  {31'h0, Pwrite},    32'h0);
        tick();
        chk("rd_acc_penable", {31'h0, Penable},   32'h1);
        chk("rd_acc_hready",  {31'h0, Hreadyout}, 32'h1);
        chk("rd_acc_pselx",   {29'h0, Pselx},     32'h1);
        chk("rd_acc_paddr",   Paddr,              32'h8000_0010);
        tick();
        chk_idle("rd_done");
        chk("rd_done_paddr", Paddr, 32'h8000_0010);

        // Single write
        valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8400_0020; tempselx = 3'b010;
        tick();
        valid = 1'b0; Hwrite = 1'b0; Hwdata = 32'hDEAD_BEEF;
        chk("wr_wait_pselx",   {29'h0, Pselx},     32'h0);
        chk("wr_wait_hready",  {31'h0, Hreadyout}, 32'h0);
        chk("wr_wait_penable", {31'h0, Penable},   32'h0);
        chk("wr_wait_paddr",   Paddr,              32'h8400_0020);
        tick();
        chk("wr_setup_pselx",   {29'h0, Pselx},     32'h2);
        chk("wr_setup_pwrite",  {31'h0, Pwrite},    32'h1);
        chk("wr_setup_pwdata",  Pwdata,             32'hDEAD_BEEF);
        chk("wr_setup_penable", {31'h0, Penable},   32'h0);
        chk("wr_setup_hready",  {31'h0, Hreadyout}, 32'h0);
        tick();
        chk("wr_acc_penable", {31'h0, Penable},   32'h1);
        chk("wr_acc_hready",  {31'h0, Hreadyout}, 32'h1);
        chk("wr_acc_pselx",   {29'h0, Pselx},     32'h2);
        tick();
        chk_idle("wr_done");
        chk("wr_done_pwdata", Pwdata, 32'hDEAD_BEEF);

        // Back-to-back: read, then a write accepted in RENABLE
        valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8800_0000; tempselx = 3'b100;
        tick();
        valid = 1'b0;
        chk("b2b_rd_setup_pselx", {29'h0, Pselx}, 32'h4);
        tick();
        chk("b2b_rd_acc_penable", {31'h0, Penable}, 32'h1);
        valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8000_0004; tempselx = 3'b001;
        tick();
        valid = 1'b0; Hwrite = 1'b0; Hwdata = 32'h1234_5678;
        chk("b2b_wwait_penable", {31'h0, Penable},   32'h0);
        chk("b2b_wwait_pselx",   {29'h0, Pselx},     32'h0);
        chk("b2b_wwait_hready",  {31'h0, Hreadyout}, 32'h0);
        chk("b2b_wwait_paddr",   Paddr,              32'h8000_0004);
        tick();
        chk("b2b_wr_setup_pselx",  {29'h0, Pselx}, 32'h1);
        chk("b2b_wr_setup_pwdata", Pwdata,         32'h1234_5678);
        tick();
        chk("b2b_wr_acc_penable", {31'h0, Penable}, 32'h1);

        // Reset mid-cycle while in WENABLE
        #2 Hresetn = 1'b0;
        #1;
        chk("midrst_pselx",   {29'h0, Pselx},     32'h0);
        chk("midrst_penable", {31'h0, Penable},   32'h0);
        chk("midrst_hready",  {31'h0, Hreadyout}, 32'h1);
        chk("midrst_paddr",   Paddr,              32'h0);
        chk("midrst_pwdata",  Pwdata,             32'h0);
        tick();
        Hresetn = 1'b1;
        tick();

        // First transfer after reset starts from IDLE
        valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8000_0100; tempselx = 3'b001;
        tick();
        valid = 1'b0;
        chk("post_rst_rd_pselx",  {29'h0, Pselx},     32'h1);
        chk("post_rst_rd_hready", {31'h0, Hreadyout}, 32'h0);
        tick();
        chk("post_rst_rd_penable", {31'h0, Penable}, 32'h1);

        // No valid for 10 cycles: idle outputs, address and data held
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_idle("novalid");
            chk("novalid_paddr",  Paddr,  32'h8000_0100);
            chk("novalid_pwdata", Pwdata, 32'h0);
        end

        // Randomised APB legality sweep
        pen_prev   = Penable;
        sel_prev   = Pselx;
        addr_prev  = Paddr;
        wdata_prev = Pwdata;
        wr_prev    = Pwrite;
        for (int i = 0; i < 1000; i++) begin
            if (Hreadyout) begin
                valid  = 1'($urandom_range(0, 1));
                Hwrite = 1'($urandom_range(0, 1));
                region = 2'($urandom_range(0, 2));
                Haddr  = {4'h8, region, 24'($urandom), 2'b00};
                tempselx = 3'b001 << region;
            end else begin
                valid = 1'b0;
            end
            Hwdata = $urandom;
            tick();
            chk("proto_penable_twice", {31'h0, pen_prev & Penable}, 32'h0);
            chk("proto_penable_sel", {31'h0, Penable && (Pselx == 3'b000)}, 32'h0);
            chk("proto_onehot0", {31'h0, (Pselx & (Pselx - 3'b001)) != 3'b000}, 32'h0);
            if (Penable) begin
                chk("proto_stable_sel",   {29'h0, Pselx}, {29'h0, sel_prev});
                chk("proto_stable_addr",  Paddr,          addr_prev);
                chk("proto_stable_wdata", Pwdata,         wdata_prev);
                chk("proto_stable_wr",    {31'h0, Pwrite}, {31'h0, wr_prev});
            end
            pen_prev   = Penable;
            sel_prev   = Pselx;
            addr_prev  = Paddr;
            wdata_prev = Pwdata;
            wr_prev    = Pwrite;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_controller.md
# apb_controller

APB-side sequencer for the AHB-to-APB bridge. It takes qualified transfers from `ahb_slave` (`valid`, `tempselx`) and turns each one into an APB SETUP/ACCESS sequence on one of three peripherals. It stalls the AHB master through `Hreadyout` while the APB transfer is in flight. Each AHB transfer maps to exactly one APB transfer, with no buffering beyond a single transfer.

## Interface
- No parameters. Widths are fixed: 32-bit address and data, 3 one-hot peripheral selects.
- `Hclk` input 1: bridge clock, rising edge.
- `Hresetn` input 1: reset, asynchronous, active-low.
- `valid` input 1: qualified AHB transfer in the current address phase, from `ahb_slave`.
- `tempselx` input 3: one-hot peripheral decode of `Haddr`, from `ahb_slave`.
- `Hwrite` input 1: AHB write flag for the current address phase.
- `Haddr` input 32: AHB address for the current address phase.
- `Hwdata` input 32: AHB write data for the current data phase.
- `Pselx` output 3: APB peripheral selects, one-hot or zero.
- `Penable` output 1: APB enable; high only in the ACCESS cycle.
- `Pwrite` output 1: APB direction; 1 = write.
- `Paddr` output 32: APB address.
- `Pwdata` output 32: APB write data.
- `Hreadyout` output 1: AHB ready, fed back to the system as `Hreadyin`.

## Operation
- All outputs are registered. They update on the `Hclk` rising edge together with the state.
- States: IDLE, READ (APB setup), RENABLE (APB access), WWAIT (waiting for write data), WRITE (APB setup), WENABLE (APB access).
- **Accept rule.** This applies in IDLE, RENABLE and WENABLE.
  - If `valid` is 1 and `Hwrite` is 0: go to READ. Load `Paddr`=`Haddr`, `Pselx`=`tempselx`, `Pwrite`=0, `Penable`=0, `Hreadyout`=0.
  - If `valid` is 1 and `Hwrite` is 1: go to WWAIT. Load `Paddr`=`Haddr` and latch `tempselx` internally. Set `Pselx`=0, `Penable`=0, `Hreadyout`=0.
  - If `valid` is 0: go to IDLE. Set `Pselx`=0, `Penable`=0, `Hreadyout`=1.
- READ: go to RENABLE. Set `Penable`=1 and `Hreadyout`=1, and hold the other outputs.
- WWAIT: go to WRITE. Load `Pwdata`=`Hwdata`, `Pselx`=latched select, `Pwrite`=1. Keep `Penable`=0 and `Hreadyout`=0.
- WRITE: go to WENABLE. Set `Penable`=1 and `Hreadyout`=1.
- While `Hreadyout`=0, `valid` is ignored in READ, WWAIT and WRITE. Because `Hreadyin`=0 then, `valid` is 0 in practice anyway.
- `Paddr`, `Pwrite` and `Pwdata` hold their last values when idle. Only `Pselx` and `Penable` return to 0.
- Back-to-back transfers, taken from RENABLE or WENABLE:
  - The next SETUP follows the ACCESS cycle directly, with no IDLE cycle in between.
  - `Pselx` may stay asserted across the two transfers. `Penable` must drop to 0 for the SETUP cycle.
- `Hrdata` is `Prdata` passed through combinationally elsewhere. The read data phase therefore completes in the RENABLE cycle, when `Hreadyout`=1 and the peripheral is driving `Prdata`.

## Timing
- Reset values, applied asynchronously the moment `Hresetn` falls: state IDLE, `Pselx`=000, `Penable`=0, `Pwrite`=0, `Paddr`=0, `Pwdata`=0, `Hreadyout`=1.
- **Reset mid-transfer.** The APB transfer is abandoned and `Pselx`/`Penable` drop immediately. After `Hresetn` releases, the first accepted transfer starts from IDLE.
- **Read.** The address phase is sampled at edge E.
  - E+1: SETUP. `Pselx`≠0, `Penable`=0, `Hreadyout`=0.
  - E+2: ACCESS. `Penable`=1, `Hreadyout`=1.
  - The AHB data phase completes at E+3.
  - This gives 1 AHB wait state.
- **Write.** The address phase is sampled at edge E.
  - E+1: WWAIT. `Hreadyout`=0.
  - E+2: SETUP. `Pwdata` captured, `Pwrite`=1.
  - E+3: ACCESS. `Hreadyout`=1.
  - The AHB data phase completes at E+4.
  - This gives 2 AHB wait states.
- **APB legality.** `Penable` is never 1 in two consecutive cycles. `Penable`=1 always implies `Pselx`≠0. `Paddr`, `Pwrite`, `Pwdata` and `Pselx` are stable from SETUP through ACCESS.
- Exactly one bit of `Pselx` is set whenever it is nonzero.

## Test plan
- **Reset.**
  - Stimulus: assert `Hresetn`=0 mid-cycle while in WENABLE.
  - Required: `Pselx`=000, `Penable`=0, `Hreadyout`=1 and `Paddr`=0 immediately, without waiting for a clock edge.
- **Single read.**
  - Stimulus: `valid`=1, `Hwrite`=0, `Haddr`=0x8000_0010, `tempselx`=001.
  - Required next cycle: `Pselx`=001, `Paddr`=0x8000_0010, `Penable`=0, `Hreadyout`=0.
  - Required the cycle after: `Penable`=1, `Hreadyout`=1.
- **Single write.**
  - Stimulus: `valid`=1, `Hwrite`=1, `Haddr`=0x8400_0020, `tempselx`=010, then `Hwdata`=0xDEAD_BEEF.
  - Required: one cycle with `Pselx`=000 and `Hreadyout`=0.
  - Then SETUP: `Pselx`=010, `Pwrite`=1, `Pwdata`=0xDEAD_BEEF, `Penable`=0.
  - Then ACCESS: `Penable`=1, `Hreadyout`=1.
- **Back-to-back.**
  - Stimulus: a read to 0x8800_0000 (`tempselx`=100), with `valid`=1 asserted in RENABLE for a write to 0x8000_0004.
  - Required: the cycle after RENABLE is WWAIT, with `Penable`=0 and `Pselx`=000. No IDLE cycle is inserted.
- **No valid.**
  - Stimulus: `valid`=0 for 10 cycles.
  - Required: state stays IDLE, `Pselx`=000, `Hreadyout`=1, and `Paddr`/`Pwdata` are unchanged.
- **Protocol checker.**
  - Stimulus: random `valid`/`Hwrite`/`Haddr` in 0x8000_0000–0x8BFF_FFFC, driven over 1000 cycles.
  - Required: `Penable` is never high for 2 consecutive cycles, `Penable`=1 always implies `Pselx`≠0, and `Pselx` is always one-hot or zero.
